// File: rtl/pipelined_decode_stage.sv
// Decode stage of the five-stage pipeline: register file, opcode decode,
// load-use / branch hazard detection, early BEQ/BNE resolution and the ID/EX register.
module pipelined_decode_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int PC_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PC_WIDTH-1:0]   programCounterIn,
  input  logic [31:0]           instruction,
  input  logic [4:0]            writeRegister,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic                  regWrite,
  input  logic                  exMemRegWrite,
  input  logic                  exMemMemRead,
  input  logic [4:0]            exMemRd,
  input  logic [DATA_WIDTH-1:0] exMemResult,
  output logic [1:0]            writeBackControl,
  output logic [1:0]            memAccessControl,
  output logic [3:0]            calculationControl,
  output logic [PC_WIDTH-1:0]   programCounterOut,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2,
  output logic [DATA_WIDTH-1:0] immediateOperand,
  output logic [4:0]            rs,
  output logic [4:0]            rt,
  output logic [4:0]            rd,
  output logic                  pcWrite,
  output logic                  ifIdWrite,
  output logic                  branch,
  output logic [PC_WIDTH-1:0]   branchProgramCounter
);

  localparam int REG_AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [5:0] NUM_REGS_L = 6'(NUM_REGS);

  logic [5:0] op_w;
  logic [4:0] rs_w, rt_w, rd_w;
  logic [15:0] imm_w;

  assign op_w  = instruction[31:26];
  assign rs_w  = instruction[25:21];
  assign rt_w  = instruction[20:16];
  assign rd_w  = instruction[15:11];
  assign imm_w = instruction[15:0];

  // R0 and indices beyond the implemented file behave as hard-wired zero
  function automatic logic addr_ok(input logic [4:0] a);
    return (a != 5'd0) && ({1'b0, a} < NUM_REGS_L);
  endfunction

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] rf_rd1, rf_rd2;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (regWrite && addr_ok(writeRegister)) begin
      regs_q[writeRegister[REG_AW-1:0]] <= writeData;
    end
  end

  always_comb begin
    rf_rd1 = '0;
    rf_rd2 = '0;
    if (addr_ok(rs_w))
      rf_rd1 = (regWrite && writeRegister == rs_w) ? writeData : regs_q[rs_w[REG_AW-1:0]];
    if (addr_ok(rt_w))
      rf_rd2 = (regWrite && writeRegister == rt_w) ? writeData : regs_q[rt_w[REG_AW-1:0]];
  end

  logic [1:0] wb_dec, mem_dec;
  logic [3:0] calc_dec;
  logic       reads_rt, is_beq, is_bne;

  always_comb begin
    wb_dec   = 2'b00;
    mem_dec  = 2'b00;
    calc_dec = 4'b0000;
    reads_rt = 1'b0;
    is_beq   = 1'b0;
    is_bne   = 1'b0;
    case (op_w)
      6'd0: begin wb_dec = 2'b10; calc_dec = 4'b1010; reads_rt = 1'b1; end
      6'd1: begin wb_dec = 2'b11; mem_dec = 2'b10; calc_dec = 4'b0100; end
      6'd2: begin mem_dec = 2'b01; calc_dec = 4'b0100; reads_rt = 1'b1; end
      6'd3: begin is_beq = 1'b1; reads_rt = 1'b1; end
      6'd4: begin wb_dec = 2'b10; calc_dec = 4'b0100; end
      6'd5: begin is_bne = 1'b1; reads_rt = 1'b1; end
      default: ;
    endcase
  end

  logic [DATA_WIDTH-1:0] imm_ext;
  logic [PC_WIDTH-1:0]   pc_off;

  always_comb begin
    imm_ext = {DATA_WIDTH{imm_w[15]}};
    imm_ext[15:0] = imm_w;
    pc_off = {PC_WIDTH{imm_w[15]}};
    pc_off[15:0] = imm_w;
  end

  // ID/EX pipeline register
  logic [1:0]            wb_q, wb_d, mem_q, mem_d;
  logic [3:0]            calc_q, calc_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [4:0]            rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;

  logic [4:0] dest_q;
  logic       load_use, branch_haz, stall, is_br;
  logic       fwd_a, fwd_b, ops_equal;
  logic [DATA_WIDTH-1:0] cmp_a, cmp_b;

  assign is_br  = is_beq | is_bne;
  assign dest_q = calc_q[3] ? rd_q : rt_q;

  assign load_use = mem_q[1] && (rt_q != 5'd0) &&
                    ((rt_q == rs_w) || (reads_rt && (rt_q == rt_w)));

  // A branch cannot forward from ID/EX, and a load in EX/MEM has no result yet
  assign branch_haz = is_br &&
    ((wb_q[1] && (dest_q != 5'd0) && ((dest_q == rs_w) || (dest_q == rt_w))) ||
     (exMemMemRead && (exMemRd != 5'd0) && ((exMemRd == rs_w) || (exMemRd == rt_w))));

  assign stall = load_use | branch_haz;

  assign fwd_a     = exMemRegWrite && (exMemRd != 5'd0) && (exMemRd == rs_w);
  assign fwd_b     = exMemRegWrite && (exMemRd != 5'd0) && (exMemRd == rt_w);
  assign cmp_a     = fwd_a ? exMemResult : rf_rd1;
  assign cmp_b     = fwd_b ? exMemResult : rf_rd2;
  assign ops_equal = (cmp_a == cmp_b);

  assign pcWrite   = ~stall;
  assign ifIdWrite = ~stall;
  assign branch    = ~stall & ((is_beq & ops_equal) | (is_bne & ~ops_equal));
  assign branchProgramCounter = programCounterIn + pc_off;

  always_comb begin
    wb_d   = wb_dec;
    mem_d  = mem_dec;
    calc_d = calc_dec;
    pc_d   = programCounterIn;
    rd1_d  = rf_rd1;
    rd2_d  = rf_rd2;
    imm_d  = imm_ext;
    rs_d   = rs_w;
    rt_d   = rt_w;
    rd_d   = rd_w;
    if (stall) begin
      wb_d   = '0;
      mem_d  = '0;
      calc_d = '0;
      pc_d   = '0;
      rd1_d  = '0;
      rd2_d  = '0;
      imm_d  = '0;
      rs_d   = '0;
      rt_d   = '0;
      rd_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_q   <= '0;
      mem_q  <= '0;
      calc_q <= '0;
      pc_q   <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
    end else begin
      wb_q   <= wb_d;
      mem_q  <= mem_d;
      calc_q <= calc_d;
      pc_q   <= pc_d;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      imm_q  <= imm_d;
      rs_q   <= rs_d;
      rt_q   <= rt_d;
      rd_q   <= rd_d;
    end
  end

  assign writeBackControl   = wb_q;
  assign memAccessControl   = mem_q;
  assign calculationControl = calc_q;
  assign programCounterOut  = pc_q;
  assign readData1          = rd1_q;
  assign readData2          = rd2_q;
  assign immediateOperand   = imm_q;
  assign rs                 = rs_q;
  assign rt                 = rt_q;
  assign rd                 = rd_q;

endmodule
